// File: rtl/fpu_ss_csr_pkg.sv
// Shared types and constants for the FPU subsystem floating-point CSR unit.
package fpu_ss_csr_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned FFLAGS_W   = 5;
  localparam int unsigned FRM_W      = 3;

  typedef enum logic [1:0] {
    CSR_RW         = 2'd0,
    CSR_RS         = 2'd1,
    CSR_RC         = 2'd2,
    CSR_OP_ILLEGAL = 2'd3
  } csr_op_e;

  localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS = 12'h001;
  localparam logic [CSR_ADDR_W-1:0] CSR_FRM    = 12'h002;
  localparam logic [CSR_ADDR_W-1:0] CSR_FCSR   = 12'h003;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    csr_op_e               op;
    logic [CSR_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       wdata;
  } csr_req_t;

  // Zicsr read-modify-write; the illegal op leaves the old value untouched.
  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/fpu_ss_fcsr_unit_if.sv
// CSR request/response bus between the offload decoder and the fcsr unit.
interface fpu_ss_fcsr_unit_if;
  import fpu_ss_csr_pkg::*;

  logic                  csr_valid;
  logic                  csr_ready;
  csr_op_e               csr_op;
  logic [CSR_ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  csr_rsp_valid;
  logic                  csr_rsp_ready;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_err;

  modport master (
    output csr_valid, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    input  csr_ready, csr_rsp_valid, csr_rdata, csr_err
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    output csr_ready, csr_rsp_valid, csr_rdata, csr_err
  );
endinterface

// File: rtl/fpu_ss_inflight_cnt.sv
// Saturating up/down counter of FPU operations outstanding.
module fpu_ss_inflight_cnt #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign empty_o = (cnt_q == '0);

  // A retire with nothing in flight means the FPU and this tracker disagree.
  no_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && empty_o));

endmodule

// File: rtl/fpu_ss_fcsr_unit.sv
// fflags/frm/fcsr CSR unit: drains in-flight FPU ops before each CSR access
// so accrued flags are ordered with respect to CSR reads and writes.
module fpu_ss_fcsr_unit
  import fpu_ss_csr_pkg::*;
#(
  parameter int unsigned      MAX_INFLIGHT = 4,
  parameter logic [FRM_W-1:0] RESET_FRM    = 3'b000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fpu_ss_fcsr_unit_if.slave   csr,
  input  logic                fpu_issue_valid_i,
  output logic                fpu_issue_ready_o,
  input  logic                fpu_out_valid_i,
  input  logic [FFLAGS_W-1:0] fpu_status_i,
  output logic [FRM_W-1:0]    frm_o,
  output logic                frm_illegal_o,
  output logic                fpu_idle_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_EXEC, S_RESP} state_e;

  state_e           state_q;
  csr_req_t         req_q;
  fflags_t          fflags_q;
  logic [FRM_W-1:0] frm_q;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             err_q;
  logic [XLEN-1:0]  rdata_q;

  logic [CNT_W-1:0] cnt;
  logic             cnt_full;
  logic             cnt_empty;
  logic             issue_fire;
  logic             drain_done;
  logic             req_err;
  logic [XLEN-1:0]  old_val;
  logic [XLEN-1:0]  new_val;

  fpu_ss_inflight_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_inflight_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (issue_fire),
    .dec_i   (fpu_out_valid_i),
    .cnt_o   (cnt),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  assign fpu_issue_ready_o = (state_q == S_IDLE) && !csr.csr_valid && !cnt_full;
  assign issue_fire        = fpu_issue_valid_i && fpu_issue_ready_o;

  // Drain completes in the cycle the last op retires, so its flags land before EXEC.
  assign drain_done = fpu_out_valid_i ? (cnt == CNT_W'(1)) : cnt_empty;

  // Read source and error decode for the captured request.
  always_comb begin
    old_val = '0;
    req_err = 1'b0;
    case (req_q.addr)
      CSR_FFLAGS: old_val = XLEN'(FFLAGS_W'(fflags_q));
      CSR_FRM:    old_val = XLEN'(frm_q);
      CSR_FCSR:   old_val = XLEN'({frm_q, FFLAGS_W'(fflags_q)});
      default:    req_err = 1'b1;
    endcase
    if (req_q.op == CSR_OP_ILLEGAL) req_err = 1'b1;
  end

  assign new_val = csr_apply(req_q.op, old_val, req_q.wdata);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= '{op: CSR_RW, addr: '0, wdata: '0};
      fflags_q    <= '0;
      frm_q       <= RESET_FRM;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (fpu_out_valid_i) fflags_q <= fflags_t'(FFLAGS_W'(fflags_q) | fpu_status_i);
      case (state_q)
        S_IDLE: begin
          if (csr.csr_valid) begin
            req_q   <= '{op: csr.csr_op, addr: csr.csr_addr, wdata: csr.csr_wdata};
            ready_q <= 1'b0;
            state_q <= (cnt_empty && !fpu_out_valid_i) ? S_EXEC : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) state_q <= S_EXEC;
        end
        S_EXEC: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
          err_q       <= req_err;
          rdata_q     <= req_err ? '0 : old_val;
          if (!req_err) begin
            if (req_q.addr != CSR_FRM)    fflags_q <= fflags_t'(new_val[FFLAGS_W-1:0]);
            if (req_q.addr == CSR_FRM)    frm_q    <= new_val[FRM_W-1:0];
            if (req_q.addr == CSR_FCSR)   frm_q    <= new_val[FFLAGS_W +: FRM_W];
          end
        end
        S_RESP: begin
          if (csr.csr_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign csr.csr_ready     = ready_q;
  assign csr.csr_rsp_valid = rsp_valid_q;
  assign csr.csr_rdata     = rdata_q;
  assign csr.csr_err       = err_q;
  assign frm_o             = frm_q;
  assign frm_illegal_o     = (frm_q > 3'd4);
  assign fpu_idle_o        = cnt_empty;

endmodule
